// File: rtl/axi_lite_bridge_pkg.sv
// axi_lite_bridge_pkg
// Definitions shared by the AXI4-Lite-to-APB bridge. Both clock domains use them, so
// the APB side decodes command and response words with the same field layout.
//   - state_t     : states of the AXI-side front end FSM
//   - grant_t     : arbitration winner, also the encoding of last_grant
//   - RESP_*      : AXI response codes carried in the response word
//   - CMD_*/RSP_* : bit positions of the fields in the command and response words,
//                   for the default 32-bit address and data widths
package axi_lite_bridge_pkg;

    localparam int AXI_ADDR_W_DEF = 32;
    localparam int AXI_DATA_W_DEF = 32;
    localparam int AXI_STRB_W_DEF = AXI_DATA_W_DEF / 8;
    localparam int CMD_W_DEF      = 1 + AXI_ADDR_W_DEF + AXI_DATA_W_DEF + AXI_STRB_W_DEF;
    localparam int RSP_W_DEF      = AXI_DATA_W_DEF + 2;

    // Command word: {is_write, addr, data, strb}, with strb in the LSBs
    localparam int CMD_STRB_LSB  = 0;
    localparam int CMD_DATA_LSB  = CMD_STRB_LSB + AXI_STRB_W_DEF;
    localparam int CMD_ADDR_LSB  = CMD_DATA_LSB + AXI_DATA_W_DEF;
    localparam int CMD_WRITE_BIT = CMD_ADDR_LSB + AXI_ADDR_W_DEF;

    // Response word: {rdata, resp}
    localparam int RSP_RESP_LSB  = 0;
    localparam int RSP_RDATA_LSB = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CAP,
        ST_CMD,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

endpackage

// File: rtl/axi_lite_rw_arb.sv
// axi_lite_rw_arb
// Chooses between a pending read and a pending write while the front end is idle.
// Build option AXI_LITE_RR_ARB_EN:
//   defined   - round-robin. A read/write tie goes to the opposite of last_grant.
//               last_grant resets to "read", so the first tie after reset goes to the write.
//   undefined - fixed write priority. There is no state, so no clock or reset ports.
// Ports:
//   wclk, wrst_n : clock and async active-low reset (round-robin build only)
//   arb_en       : front end is idle and can accept a grant
//   wr_req       : AWVALID or WVALID is high
//   rd_req       : ARVALID is high
//   grant_wr     : write wins this cycle
//   grant_rd     : read wins this cycle
module axi_lite_rw_arb
    import axi_lite_bridge_pkg::*;
(
`ifdef AXI_LITE_RR_ARB_EN
    input  logic wclk,
    input  logic wrst_n,
`endif
    input  logic arb_en,
    input  logic wr_req,
    input  logic rd_req,
    output logic grant_wr,
    output logic grant_rd
);

`ifdef AXI_LITE_RR_ARB_EN
    grant_t last_grant;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (arb_en) begin
            if (wr_req && rd_req) begin
                grant_wr = (last_grant == GRANT_RD);
                grant_rd = (last_grant == GRANT_WR);
            end else begin
                grant_wr = wr_req;
                grant_rd = rd_req;
            end
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            last_grant <= GRANT_RD;
        end else if (grant_wr) begin
            last_grant <= GRANT_WR;
        end else if (grant_rd) begin
            last_grant <= GRANT_RD;
        end
    end
`else
    // A read waits while either half of a write is still being offered.
    assign grant_wr = arb_en & wr_req;
    assign grant_rd = arb_en & rd_req & ~wr_req;
`endif

endmodule

// File: rtl/axi_lite_slave_if.sv
// axi_lite_slave_if
// AXI4-Lite slave front end for the wclk side of the AXI4-Lite-to-APB bridge.
// Only one transaction is outstanding at a time. A granted read, or a write built from
// AW and W, becomes one command word that is pushed into the command async FIFO. The
// matching response word is then popped from the response async FIFO and returned
// on B or R.
// Build option AXI_LITE_RR_ARB_EN selects round-robin arbitration; the default is
// fixed write priority (see axi_lite_rw_arb).
// Ports:
//   wclk, wrst_n                    : clock, async active-low reset
//   s_aw*, s_w*, s_b*               : AXI4-Lite write address, write data, write response
//   s_ar*, s_r*                     : AXI4-Lite read address, read data
//   cmd_winc, cmd_wdata, cmd_wfull  : command FIFO write side
//   rsp_rinc, rsp_rdata, rsp_rempty : response FIFO read side
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate AW/W against AR
// ST_WR_CAP | write granted; collect AW and W in any order
// ST_CMD    | command word held stable; push when FIFO has room
// ST_WAIT   | waiting for the response word; pop when it arrives
// ST_RESP   | B or R valid held until the master accepts it
module axi_lite_slave_if
    import axi_lite_bridge_pkg::*;
#(
    parameter  int AXI_ADDR_W = AXI_ADDR_W_DEF,
    parameter  int AXI_DATA_W = AXI_DATA_W_DEF,
    localparam int STRB_W     = AXI_DATA_W / 8,
    localparam int CMD_W      = 1 + AXI_ADDR_W + AXI_DATA_W + STRB_W,
    localparam int RSP_W      = AXI_DATA_W + 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,

    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [AXI_ADDR_W-1:0] s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [AXI_DATA_W-1:0] s_wdata,
    input  logic [STRB_W-1:0]     s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,

    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [AXI_ADDR_W-1:0] s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [AXI_DATA_W-1:0] s_rdata,
    output logic [1:0]            s_rresp,

    output logic                  cmd_winc,
    output logic [CMD_W-1:0]      cmd_wdata,
    input  logic                  cmd_wfull,

    output logic                  rsp_rinc,
    input  logic [RSP_W-1:0]      rsp_rdata,
    input  logic                  rsp_rempty
);

    state_t                state;
    state_t                state_nxt;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  aw_got;
    logic                  w_got;
    logic                  is_write;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            resp_q;
    logic [AXI_DATA_W-1:0] rdata_q;
    logic                  bvalid_q;
    logic                  rvalid_q;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  resp_done;

    axi_lite_rw_arb u_arb (
`ifdef AXI_LITE_RR_ARB_EN
        .wclk     (wclk),
        .wrst_n   (wrst_n),
`endif
        .arb_en   (state == ST_IDLE),
        .wr_req   (s_awvalid | s_wvalid),
        .rd_req   (s_arvalid),
        .grant_wr (grant_wr),
        .grant_rd (grant_rd)
    );

    assign aw_fire   = s_awvalid & s_awready;
    assign w_fire    = s_wvalid & s_wready;
    assign resp_done = (state == ST_RESP) & ((bvalid_q & s_bready) | (rvalid_q & s_rready));

    always_comb begin
        state_nxt = state;
        s_arready = 1'b0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        cmd_winc  = 1'b0;
        rsp_rinc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_wr) begin
                    state_nxt = ST_WR_CAP;
                end else if (grant_rd) begin
                    s_arready = 1'b1;
                    state_nxt = ST_CMD;
                end
            end
            ST_WR_CAP: begin
                s_awready = ~aw_got;
                s_wready  = ~w_got;
                // A flag already set and a handshake in this cycle both count as captured.
                if ((aw_got | (s_awvalid & ~aw_got)) && (w_got | (s_wvalid & ~w_got))) begin
                    state_nxt = ST_CMD;
                end
            end
            ST_CMD: begin
                cmd_winc = ~cmd_wfull;
                if (!cmd_wfull) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rsp_rinc = ~rsp_rempty;
                if (!rsp_rempty) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= ST_IDLE;
            aw_got   <= 1'b0;
            w_got    <= 1'b0;
            is_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            resp_q   <= '0;
            rdata_q  <= '0;
            bvalid_q <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_rd) begin
                // A read's command word carries zero data and strobe.
                is_write <= 1'b0;
                addr_q   <= s_araddr;
                wdata_q  <= '0;
                wstrb_q  <= '0;
            end
            if (grant_wr) begin
                is_write <= 1'b1;
            end
            if (aw_fire) begin
                aw_got <= 1'b1;
                addr_q <= s_awaddr;
            end
            if (w_fire) begin
                w_got   <= 1'b1;
                wdata_q <= s_wdata;
                wstrb_q <= s_wstrb;
            end
            if (rsp_rinc) begin
                resp_q   <= rsp_rdata[RSP_RESP_LSB +: 2];
                bvalid_q <= is_write;
                rvalid_q <= ~is_write;
                if (!is_write) begin
                    rdata_q <= rsp_rdata[RSP_RDATA_LSB +: AXI_DATA_W];
                end
            end
            if (resp_done) begin
                aw_got   <= 1'b0;
                w_got    <= 1'b0;
                bvalid_q <= 1'b0;
                rvalid_q <= 1'b0;
            end
        end
    end

    assign cmd_wdata = {is_write, addr_q, wdata_q, wstrb_q};
    assign s_bvalid  = bvalid_q;
    assign s_rvalid  = rvalid_q;
    assign s_bresp   = resp_q;
    assign s_rresp   = resp_q;
    assign s_rdata   = rdata_q;

endmodule

// File: doc/axi_lite_slave_if.md
# axi_lite_slave_if

AXI4-Lite slave front end on the AXI clock domain of the AXI4-Lite-to-APB bridge. It arbitrates between the read and write address channels, joins AW and W into a single command word, and pushes that word into the command async FIFO. It then pops the matching response word from the response async FIFO (read side on wclk) and returns it on B or R. One transaction is outstanding at a time.

## Interface
- AXI_ADDR_W, 32, AXI address width
- AXI_DATA_W, 32, AXI data width; strobe width is AXI_DATA_W/8
- CMD_W, 1+AXI_ADDR_W+AXI_DATA_W+AXI_DATA_W/8 (69 at defaults), command word width
- RSP_W, AXI_DATA_W+2 (34), response word width

Ports:
- wclk  in  1  AXI-domain clock
- wrst_n  in  1  asynchronous, active-low reset
- s_awvalid/s_awready  in/out  1  write address handshake; s_awaddr  in  AXI_ADDR_W
- s_wvalid/s_wready  in/out  1  write data handshake; s_wdata  in  AXI_DATA_W; s_wstrb  in  AXI_DATA_W/8
- s_bvalid/s_bready  out/in  1  write response handshake; s_bresp  out  2
- s_arvalid/s_arready  in/out  1  read address handshake; s_araddr  in  AXI_ADDR_W
- s_rvalid/s_rready  out/in  1  read data handshake; s_rdata  out  AXI_DATA_W; s_rresp  out  2
- cmd_winc  out  1  push to command FIFO
- cmd_wdata  out  CMD_W  command word
- cmd_wfull  in  1  command FIFO full
- rsp_rinc  out  1  pop from response FIFO
- rsp_rdata  in  RSP_W  response word, valid while !rsp_rempty
- rsp_rempty  in  1  response FIFO empty

## Operation
- Command word layout: [CMD_W-1] is_write, then addr, then data, then strb in the LSBs. Reads carry data=0 and strb=0.
- Response word layout: [1:0] resp (00 OKAY, 10 SLVERR), [RSP_W-1:2] rdata. Writes ignore rdata.
- FSM states: IDLE, WR_CAP, CMD, WAIT, RESP.
- IDLE:
  - s_awready = 0 and s_wready = 0.
  - Write is requested when s_awvalid or s_wvalid is high. Read is requested when s_arvalid is high.
  - Granted write: go to WR_CAP.
  - Granted read: s_arready = 1 combinationally, latch s_araddr, go to CMD.
- WR_CAP:
  - s_awready = !aw_got and s_wready = !w_got. aw_got and w_got are internal capture flags.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are captured (the same-cycle case counts), go to CMD.
- CMD: cmd_winc = !cmd_wfull. On push, go to WAIT. While the FIFO is full, stay in CMD with cmd_wdata held stable.
- WAIT: rsp_rinc = !rsp_rempty. On pop, latch rsp_rdata into the resp/rdata registers and go to RESP.
- RESP:
  - Assert s_bvalid if the transaction is a write, otherwise s_rvalid.
  - Hold the valid and payload until ready; on handshake, go to IDLE and clear aw_got and w_got.
- At most one of s_bvalid and s_rvalid is high at any time. cmd_winc and rsp_rinc are never high outside CMD and WAIT respectively.

## Timing
- Reset values: state=IDLE; every ready, every valid, cmd_winc and rsp_rinc = 0; s_bresp = 0, s_rresp = 0, s_rdata = 0; capture flags cleared; last_grant = read.
- Read latency: AR handshake at cycle 0, then cmd_winc at cycle 1 if the FIFO is not full.
- Write latency: grant at cycle 0, AW and W captured at cycle 1 (same cycle), then cmd_winc at cycle 2.
- Response: pop at cycle N, then s_bvalid or s_rvalid at cycle N+1.
- The valid signal in RESP is registered. Ready signals are combinational from state and the capture flags.
- Reset asserted mid-transaction: return to IDLE immediately, and drop the outstanding transaction with no B or R issued.

## Configuration
- AXI_LITE_RR_ARB_EN defined: round-robin arbitration. On a read/write tie, grant the opposite of last_grant. last_grant updates on each grant, so after reset the first tie goes to the write.
- Undefined: fixed write priority. A read is granted only when s_awvalid and s_wvalid are both low. last_grant is not implemented.

## Structure
- Package axi_lite_bridge_pkg holds:
  - the state enum typedef;
  - the RESP_OKAY and RESP_SLVERR constants;
  - the cmd/rsp field-position localparams, so the APB side decodes the same layout.
- Sub-module axi_lite_rw_arb holds the grant logic and last_grant register, including the AXI_LITE_RR_ARB_EN variants.

## Test plan
- Read, FIFO empty then rsp=34'h0_DEAD_BEEF<<2|00 after 5 cycles: araddr 32'h10 produces a cmd word with is_write=0 and addr 32'h10; s_rdata=32'hDEADBEEF, s_rresp=00, one R beat.
- Write with W one cycle before AW (wdata 32'hA5A5_0001, wstrb 4'hF, awaddr 32'h20): a single push with is_write=1 and the correct fields; rsp resp=10 returns s_bresp=10.
- cmd_wfull held high for 4 cycles in CMD: no push and cmd_wdata stable; push occurs the first cycle after wfull drops.
- AWVALID and ARVALID asserted together, twice back-to-back: with RR_EN the order is write then read; without it, write then write, and the read stays blocked while AW is pending.
- s_rready held low for 3 cycles in RESP: s_rvalid and s_rdata stable; rsp_rinc stays 0 for any new response data.
- wrst_n pulsed while in WAIT: all outputs return to their reset values; the next read completes normally.
